pa_pg_cmd_scheduler: RTL

PA_PG_CMD_SCHEDULER -- requirements
Module: pa_pg_cmd_scheduler

---
 rtl/pa_pg_sched_pkg.sv | 28 ++
 rtl/pa_pg_cmd_scheduler_if.sv | 28 ++
 rtl/pa_pg_cmd_scheduler_rr_arb2.sv | 44 ++++
 rtl/pa_pg_cmd_scheduler.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pa_pg_sched_pkg.sv
// Package for the pa/pg command scheduler.
// Holds the scheduler state encoding, the pa/pg command codes and small
// helpers shared by the scheduler RTL.
package pa_pg_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_e;

    localparam logic [1:0] CMD_STOP      = 2'd0;
    localparam logic [1:0] CMD_START     = 2'd1;
    localparam logic [1:0] CMD_CLR_STATS = 2'd2;
    localparam logic [1:0] CMD_SNAPSHOT  = 2'd3;

    // Requester index to one-hot grant/ready/done vector.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        logic [1:0] vec;
        if (idx) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/pa_pg_cmd_scheduler_if.sv
// Requester and command-stream bundle of the pa/pg command scheduler.
//   req_valid[1:0]  : requester i offers a command
//   req_ready[1:0]  : requester i's command accepted this cycle
//   req_cmd[3:0]    : 2-bit command code per requester
//   req_rpt         : CNT_W-bit repeat count per requester (beats = rpt+1)
//   out_valid/out_ready/out_data : Avalon-ST command beat stream
// master = scheduler side, slave = requesters plus downstream sink.
interface pa_pg_cmd_scheduler_if #(
    parameter int CNT_W = 8
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [3:0]         req_cmd;
    logic [2*CNT_W-1:0] req_rpt;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_data;

    modport master (
        input  req_valid, req_cmd, req_rpt, out_ready,
        output req_ready, out_valid, out_data
    );

    modport slave (
        output req_valid, req_cmd, req_rpt, out_ready,
        input  req_ready, out_valid, out_data
    );
endinterface

// File: rtl/pa_pg_cmd_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, reset_n : clock, synchronous active-low reset
//   req[1:0]     : request vector
//   upd_en       : record upd_idx as the last-served requester
//   upd_idx      : requester index that was just served (or aborted)
//   gnt_any      : at least one request present
//   gnt_idx      : index of the winning requester (combinational)
// After reset the last-served pointer is 1, so requester 0 wins a tie first.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       upd_en,
    input  logic       upd_idx,
    output logic       gnt_any,
    output logic       gnt_idx
);

    logic last_r;

    // Pick the requester: a lone request always wins, a tie goes to the one not served last.
    always_comb begin
        gnt_any = |req;
        if (req == 2'b11) begin
            gnt_idx = ~last_r;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end else begin
            gnt_idx = 1'b0;
        end
    end

    // Last-served pointer register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_r <= 1'b1;
        end else if (upd_en) begin
            last_r <= upd_idx;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/pa_pg_cmd_scheduler.sv
// pa/pg command scheduler: arbitrates two requesters, then streams the
// winner's command code rpt+1 times over an Avalon-ST link, followed by a
// fixed idle gap.
//   clk, reset_n : clock, synchronous active-low reset
//   flush        : abort the current command, back to IDLE, no done
//   bus          : requester handshake and out stream (master modport)
//   grant[1:0]   : one-hot owner of the current command, 0 in IDLE
//   done[1:0]    : one-cycle pulse when requester i's command has fully issued
//   busy         : state is not IDLE
module pa_pg_cmd_scheduler
    import pa_pg_sched_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    pa_pg_cmd_scheduler_if.master bus,
    output logic [1:0]            grant,
    output logic [1:0]            done,
    output logic                  busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Gap counter counts down to zero, so it is loaded with GAP_CYCLES-1.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : {GAP_W{1'b0}};

    sched_state_e     state_r, state_nxt_s;
    logic             owner_r, owner_nxt_s;
    logic [1:0]       cmd_r, cmd_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [GAP_W-1:0] gap_r, gap_nxt_s;
    logic [1:0]       done_nxt_s;
    logic [1:0]       req_ready_s;
    logic             upd_en_s;
    logic             arb_any_s;
    logic             arb_idx_s;
    logic             xfer_s;

    logic             out_valid_r;
    logic [1:0]       out_data_r;
    logic [1:0]       grant_r;
    logic [1:0]       done_r;
    logic             busy_r;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .upd_en  (upd_en_s),
        .upd_idx (owner_r),
        .gnt_any (arb_any_s),
        .gnt_idx (arb_idx_s)
    );

    assign xfer_s = out_valid_r & bus.out_ready;

    // Next-state, capture and pointer-update logic; req_ready is a same-cycle grant strobe.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        cmd_nxt_s   = cmd_r;
        cnt_nxt_s   = cnt_r;
        gap_nxt_s   = gap_r;
        done_nxt_s  = 2'b00;
        req_ready_s = 2'b00;
        upd_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Reset and flush both block a grant in this cycle.
                if (reset_n && !flush && arb_any_s) begin
                    req_ready_s = idx_to_onehot(arb_idx_s);
                    owner_nxt_s = arb_idx_s;
                    cmd_nxt_s   = arb_idx_s ? bus.req_cmd[3:2] : bus.req_cmd[1:0];
                    cnt_nxt_s   = arb_idx_s ? bus.req_rpt[2*CNT_W-1:CNT_W] : bus.req_rpt[CNT_W-1:0];
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // A flush coinciding with the final beat still lets the beat go, but eats the done.
                if (flush) begin
                    upd_en_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (xfer_s) begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        done_nxt_s  = idx_to_onehot(owner_r);
                        upd_en_s    = 1'b1;
                        gap_nxt_s   = GAP_LOAD;
                        state_nxt_s = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_GAP: begin
                if (flush) begin
                    upd_en_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (gap_r == {GAP_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_nxt_s = gap_r - {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, capture registers and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            owner_r     <= 1'b0;
            cmd_r       <= CMD_STOP;
            cnt_r       <= {CNT_W{1'b0}};
            gap_r       <= {GAP_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= CMD_STOP;
            grant_r     <= 2'b00;
            done_r      <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            cmd_r       <= cmd_nxt_s;
            cnt_r       <= cnt_nxt_s;
            gap_r       <= gap_nxt_s;
            out_valid_r <= (state_nxt_s == ST_ISSUE);
            out_data_r  <= (state_nxt_s == ST_ISSUE) ? cmd_nxt_s : CMD_STOP;
            grant_r     <= (state_nxt_s != ST_IDLE) ? idx_to_onehot(owner_nxt_s) : 2'b00;
            done_r      <= done_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign grant         = grant_r;
    assign done          = done_r;
    assign busy          = busy_r;

endmodule
